// File: rtl/mbinit_param_wrapper_if.sv
// Signal bundle between the MBINIT controller / sideband codec side and the
// MBINIT.PARAM wrapper. The controller side uses "master", the wrapper "slave".
interface mbinit_param_wrapper_if #(
   parameter int SB_MSG_Width = 4
);
   logic                    i_MBINIT_en;
   logic [SB_MSG_Width-1:0] i_decoded_sb_msg;
   logic                    i_sb_valid;
   logic                    i_sb_busy;
   logic                    i_falling_edge_busy;
   logic                    i_pass_tx;
   logic                    i_finish_tx;
   logic                    i_finish_rx;
   logic [SB_MSG_Width-1:0] o_encoded_SB_msg;
   logic                    o_msg_valid;
   logic                    o_error_req;
   logic                    check_TX;
   logic                    check_RX;
   logic                    o_PARAM_END;

   modport master (
      output i_MBINIT_en, i_decoded_sb_msg, i_sb_valid, i_sb_busy,
             i_falling_edge_busy, i_pass_tx, i_finish_tx, i_finish_rx,
      input  o_encoded_SB_msg, o_msg_valid, o_error_req, check_TX,
             check_RX, o_PARAM_END
   );

   modport slave (
      input  i_MBINIT_en, i_decoded_sb_msg, i_sb_valid, i_sb_busy,
             i_falling_edge_busy, i_pass_tx, i_finish_tx, i_finish_rx,
      output o_encoded_SB_msg, o_msg_valid, o_error_req, check_TX,
             check_RX, o_PARAM_END
   );
endinterface

// File: rtl/mbinit_param_wrapper.sv
// MBINIT.PARAM handshake for one die. A TX sub-FSM sends our REQ and waits
// for the partner's RESP (validated externally); an RX sub-FSM waits for the
// partner's REQ (checked externally) and answers with RESP. Both share one
// registered sideband output slot, TX having priority.
// Optional build macro: PARAM_TIMEOUT_EN adds a wait-state timeout
// (TIMEOUT_CYCLES) that raises o_error_req and freezes both FSMs.
module mbinit_param_wrapper #(
   parameter int SB_MSG_Width = 4
`ifdef PARAM_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 8000
`endif
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   mbinit_param_wrapper_if.slave   bus
);

   localparam logic [2:0] TX_IDLE      = 3'd0;
   localparam logic [2:0] TX_SEND_REQ  = 3'd1;
   localparam logic [2:0] TX_WAIT_RESP = 3'd2;
   localparam logic [2:0] TX_CHECK     = 3'd3;
   localparam logic [2:0] TX_DONE      = 3'd4;
   localparam logic [2:0] TX_ERROR     = 3'd5;

   localparam logic [2:0] RX_IDLE      = 3'd0;
   localparam logic [2:0] RX_WAIT_REQ  = 3'd1;
   localparam logic [2:0] RX_CHECK     = 3'd2;
   localparam logic [2:0] RX_SEND_RESP = 3'd3;
   localparam logic [2:0] RX_DONE      = 3'd4;

   localparam logic [SB_MSG_Width-1:0] MSG_REQ  = SB_MSG_Width'(1);
   localparam logic [SB_MSG_Width-1:0] MSG_RESP = SB_MSG_Width'(2);

   logic [2:0]              tx_state, tx_next;
   logic [2:0]              rx_state, rx_next;
   logic                    clear;
   logic                    req_seen, resp_seen;
   logic                    req_shown, resp_shown;
   logic                    msg_valid;
   logic [SB_MSG_Width-1:0] msg_code;
   logic                    freeze;
   logic                    timeout_err;
   logic                    unused_busy;

   // Busy level is informational only; progress is driven by the falling-edge strobe.
   assign unused_busy = bus.i_sb_busy;

   // Disable behaves exactly like reset: both FSMs and all outputs cleared.
   assign clear = i_rst || !bus.i_MBINIT_en;

   assign req_seen  = bus.i_sb_valid && (bus.i_decoded_sb_msg == MSG_REQ);
   assign resp_seen = bus.i_sb_valid && (bus.i_decoded_sb_msg == MSG_RESP);

   // A send-complete strobe only retires the message actually on the wire.
   assign req_shown  = bus.o_msg_valid && (bus.o_encoded_SB_msg == MSG_REQ);
   assign resp_shown = bus.o_msg_valid && (bus.o_encoded_SB_msg == MSG_RESP);

`ifdef PARAM_TIMEOUT_EN
   logic [15:0] wait_cnt;
   logic        timeout_hit;
   logic        waiting;
   logic        timeout_now;

   assign waiting     = (tx_state == TX_WAIT_RESP) || (rx_state == RX_WAIT_REQ);
   assign timeout_now = !timeout_hit && waiting && (wait_cnt == 16'(TIMEOUT_CYCLES - 1));
   assign freeze      = timeout_hit || timeout_now;
   assign timeout_err = timeout_hit || timeout_now;

   // Count cycles spent in either wait state; the hit flag sticks until cleared.
   always_ff @(posedge i_clk) begin
      if (clear) begin
         wait_cnt    <= '0;
         timeout_hit <= 1'b0;
      end else if (timeout_now) begin
         timeout_hit <= 1'b1;
      end else if (!timeout_hit) begin
         if (waiting) wait_cnt <= wait_cnt + 16'd1;
         else         wait_cnt <= '0;
      end
   end
`else
   assign freeze      = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // TX sub-FSM: send REQ, wait for partner RESP, await external verdict.
   always_comb begin
      tx_next = tx_state;
      if (!freeze) begin
         case (tx_state)
            TX_IDLE:      tx_next = TX_SEND_REQ;
            TX_SEND_REQ:  if (bus.i_falling_edge_busy && req_shown) tx_next = TX_WAIT_RESP;
            TX_WAIT_RESP: if (resp_seen) tx_next = TX_CHECK;
            TX_CHECK:     if (bus.i_finish_tx) tx_next = bus.i_pass_tx ? TX_DONE : TX_ERROR;
            default:      tx_next = tx_state;
         endcase
      end
   end

   // RX sub-FSM: wait for partner REQ, await local check, answer with RESP.
   always_comb begin
      rx_next = rx_state;
      if (!freeze) begin
         case (rx_state)
            RX_IDLE:      rx_next = RX_WAIT_REQ;
            RX_WAIT_REQ:  if (req_seen) rx_next = RX_CHECK;
            RX_CHECK:     if (bus.i_finish_rx) rx_next = RX_SEND_RESP;
            RX_SEND_RESP: if (bus.i_falling_edge_busy && resp_shown) rx_next = RX_DONE;
            default:      rx_next = rx_state;
         endcase
      end
   end

   // Output slot arbitration: TX request beats a pending RX response.
   always_comb begin
      msg_valid = 1'b0;
      msg_code  = '0;
      if (tx_state == TX_SEND_REQ) begin
         msg_valid = 1'b1;
         msg_code  = MSG_REQ;
      end else if (rx_state == RX_SEND_RESP) begin
         msg_valid = 1'b1;
         msg_code  = MSG_RESP;
      end
   end

   // State registers for both sub-FSMs.
   always_ff @(posedge i_clk) begin
      if (clear) begin
         tx_state <= TX_IDLE;
         rx_state <= RX_IDLE;
      end else begin
         tx_state <= tx_next;
         rx_state <= rx_next;
      end
   end

   // Registered outputs; the sideband message follows the current state one
   // cycle later, status flags track the state being entered.
   always_ff @(posedge i_clk) begin
      if (clear) begin
         bus.o_encoded_SB_msg <= '0;
         bus.o_msg_valid      <= 1'b0;
         bus.o_error_req      <= 1'b0;
         bus.check_TX         <= 1'b0;
         bus.check_RX         <= 1'b0;
         bus.o_PARAM_END      <= 1'b0;
      end else begin
         bus.o_encoded_SB_msg <= msg_code;
         bus.o_msg_valid      <= msg_valid;
         bus.o_error_req      <= (tx_next == TX_ERROR) || timeout_err;
         bus.check_TX         <= (tx_next == TX_CHECK);
         bus.check_RX         <= (rx_next == RX_CHECK);
         bus.o_PARAM_END      <= (tx_next == TX_DONE) && (rx_next == RX_DONE) && !timeout_err;
      end
   end

endmodule

// File: tb/tb_mbinit_param_wrapper.sv
// Two cross-connected PARAM wrappers (die A = index 0, die B = index 1) with a
// sideband model that strobes send-complete a few cycles after each message.
module tb_mbinit_param_wrapper;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       en[2], fin_rx[2], fin_tx[2], pass_tx[2], feb[2], busy[2];
   logic       vld[2], err[2], ctx[2], crx[2], pend[2];
   logic [3:0] code[2];
   int         checks = 0;
   int         failures = 0;
   int         n_req[2], n_resp[2];

   mbinit_param_wrapper_if #(.SB_MSG_Width(4)) if_a ();
   mbinit_param_wrapper_if #(.SB_MSG_Width(4)) if_b ();

   assign if_a.i_MBINIT_en         = en[0];
   assign if_a.i_decoded_sb_msg    = if_b.o_encoded_SB_msg;
   assign if_a.i_sb_valid          = if_b.o_msg_valid;
   assign if_a.i_sb_busy           = busy[0];
   assign if_a.i_falling_edge_busy = feb[0];
   assign if_a.i_pass_tx           = pass_tx[0];
   assign if_a.i_finish_tx         = fin_tx[0];
   assign if_a.i_finish_rx         = fin_rx[0];
   assign if_b.i_MBINIT_en         = en[1];
   assign if_b.i_decoded_sb_msg    = if_a.o_encoded_SB_msg;
   assign if_b.i_sb_valid          = if_a.o_msg_valid;
   assign if_b.i_sb_busy           = busy[1];
   assign if_b.i_falling_edge_busy = feb[1];
   assign if_b.i_pass_tx           = pass_tx[1];
   assign if_b.i_finish_tx         = fin_tx[1];
   assign if_b.i_finish_rx         = fin_rx[1];

   assign vld[0] = if_a.o_msg_valid;   assign vld[1] = if_b.o_msg_valid;
   assign code[0] = if_a.o_encoded_SB_msg; assign code[1] = if_b.o_encoded_SB_msg;
   assign err[0] = if_a.o_error_req;   assign err[1] = if_b.o_error_req;
   assign ctx[0] = if_a.check_TX;      assign ctx[1] = if_b.check_TX;
   assign crx[0] = if_a.check_RX;      assign crx[1] = if_b.check_RX;
   assign pend[0] = if_a.o_PARAM_END;  assign pend[1] = if_b.o_PARAM_END;

   mbinit_param_wrapper #(.SB_MSG_Width(4)) dut_a (.i_clk(clk), .i_rst(rst), .bus(if_a.slave));
   mbinit_param_wrapper #(.SB_MSG_Width(4)) dut_b (.i_clk(clk), .i_rst(rst), .bus(if_b.slave));

   // Reference outcome for one die: its RX side always answers, so completion
   // hinges only on whether its own TX verdict accepted the partner's response.
   // Returns {error_expected, end_expected}.
   function automatic logic [1:0] model_outcome(input bit pass_own);
      return pass_own ? 2'b01 : 2'b10;
   endfunction

   // Sideband model and message monitor: busy rises when a message appears,
   // the send-complete strobe follows 1..3 cycles later; new messages counted.
   initial begin
      int   phase[2];
      int   cnt[2];
      logic pv[2];
      logic [3:0] pc[2];
      for (int d = 0; d < 2; d++) begin
         phase[d] = 0; cnt[d] = 0; pv[d] = 1'b0; pc[d] = 4'd0;
         feb[d] = 1'b0; busy[d] = 1'b0; n_req[d] = 0; n_resp[d] = 0;
      end
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (vld[d] && (!pv[d] || code[d] != pc[d])) begin
               if (code[d] == 4'd1) n_req[d] = n_req[d] + 1;
               else if (code[d] == 4'd2) n_resp[d] = n_resp[d] + 1;
            end
            pv[d] = vld[d];
            pc[d] = code[d];
            case (phase[d])
               0: if (vld[d]) begin busy[d] = 1'b1; cnt[d] = $urandom_range(1, 3); phase[d] = 1; end
               1: begin
                  cnt[d] = cnt[d] - 1;
                  if (cnt[d] == 0) begin feb[d] = 1'b1; phase[d] = 2; end
               end
               default: begin feb[d] = 1'b0; busy[d] = 1'b0; phase[d] = 0; end
            endcase
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic go_idle();
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         en[d] = 1'b0; fin_rx[d] = 1'b0; fin_tx[d] = 1'b0; pass_tx[d] = 1'b0;
      end
      cycles(8);
   endtask

   // Drives one die's external check strobes once its checks are requested.
   task automatic die_flow(input int d, input bit pass, output bit got_crx, output bit got_ctx);
      int t;
      t = 0;
      while (!crx[d] && t < 60) begin @(negedge clk); t++; end
      got_crx = crx[d];
      got_ctx = 1'b0;
      if (got_crx) begin
         cycles($urandom_range(3, 8));
         fin_rx[d] = 1'b1;
         @(negedge clk);
         fin_rx[d] = 1'b0;
         t = 0;
         while (!ctx[d] && t < 80) begin @(negedge clk); t++; end
         got_ctx = ctx[d];
         if (got_ctx) begin
            cycles($urandom_range(0, 4));
            pass_tx[d] = pass;
            fin_tx[d] = 1'b1;
            @(negedge clk);
            fin_tx[d] = 1'b0;
            pass_tx[d] = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      go_idle();
      en[0] = 1'b1; en[1] = 1'b1; rst = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({vld[d], code[d], err[d], ctx[d], crx[d], pend[d]} !== 9'd0) begin
            failures++;
            $display("FAIL reset_outs die%0d got=%b want=0", d, {vld[d], code[d], err[d], ctx[d], crx[d], pend[d]});
         end
      end
      rst = 1'b0;
      cycles(4);
      checks++;
      if (vld[0] !== 1'b1 || code[0] !== 4'd1) begin
         failures++;
         $display("FAIL req_after_reset got vld=%b code=%h want vld=1 code=1", vld[0], code[0]);
      end
      en[0] = 1'b0; en[1] = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if ({vld[d], code[d], err[d], ctx[d], crx[d], pend[d]} !== 9'd0) begin
            failures++;
            $display("FAIL disable_outs die%0d got=%b want=0", d, {vld[d], code[d], err[d], ctx[d], crx[d], pend[d]});
         end
      end
   endtask

   task automatic test_handshake(input int iters);
      for (int it = 0; it < iters; it++) begin
         bit pass[2];
         bit seen_req[2];
         bit gcr0, gct0, gcr1, gct1;
         int req0[2], resp0[2];
         logic [1:0] exp[2];
         int t;
         if (it == 0)      begin pass[0] = 1'b0; pass[1] = 1'b1; end
         else if (it == 1) begin pass[0] = 1'b1; pass[1] = 1'b1; end
         else              begin pass[0] = 1'($urandom); pass[1] = 1'($urandom); end
         go_idle();
         for (int d = 0; d < 2; d++) begin
            exp[d] = model_outcome(pass[d]);
            req0[d] = n_req[d]; resp0[d] = n_resp[d]; seen_req[d] = 1'b0;
         end
         en[0] = 1'b1; en[1] = 1'b1;
         for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) if (vld[d] && code[d] == 4'd1) seen_req[d] = 1'b1;
         end
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (seen_req[d] !== 1'b1) begin
               failures++;
               $display("FAIL req_within_5 it%0d die%0d got=%b want=1", it, d, seen_req[d]);
            end
         end
         fork
            die_flow(0, pass[0], gcr0, gct0);
            die_flow(1, pass[1], gcr1, gct1);
         join
         checks++;
         if ({gcr0, gct0, gcr1, gct1} !== 4'b1111) begin
            failures++;
            $display("FAIL check_requests it%0d got=%b want=1111", it, {gcr0, gct0, gcr1, gct1});
         end
         t = 0;
         while (!((pend[0] || err[0]) && (pend[1] || err[1])) && t < 40) begin @(negedge clk); t++; end
         cycles(8);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if ({err[d], pend[d]} !== exp[d]) begin
               failures++;
               $display("FAIL outcome it%0d die%0d got err/end=%b want=%b", it, d, {err[d], pend[d]}, exp[d]);
            end
            checks++;
            if ((n_req[d] - req0[d]) !== 1 || (n_resp[d] - resp0[d]) !== 1) begin
               failures++;
               $display("FAIL msg_count it%0d die%0d got req=%0d resp=%0d want 1/1", it, d,
                        n_req[d] - req0[d], n_resp[d] - resp0[d]);
            end
            checks++;
            if ({vld[d], ctx[d], crx[d]} !== 3'b000) begin
               failures++;
               $display("FAIL quiet_after it%0d die%0d got vld/ctx/crx=%b want 000", it, d, {vld[d], ctx[d], crx[d]});
            end
         end
         if (!pass[0] || !pass[1]) begin
            cycles(10);
            for (int d = 0; d < 2; d++) begin
               if (!pass[d]) begin
                  checks++;
                  if (err[d] !== 1'b1 || pend[d] !== 1'b0) begin
                     failures++;
                     $display("FAIL error_sticky it%0d die%0d got err=%b end=%b want 1/0", it, d, err[d], pend[d]);
                  end
               end
            end
         end
         en[0] = 1'b0; en[1] = 1'b0;
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (err[d] !== 1'b0 || pend[d] !== 1'b0) begin
               failures++;
               $display("FAIL disable_clears it%0d die%0d got err=%b end=%b want 0/0", it, d, err[d], pend[d]);
            end
         end
      end
   endtask

   task automatic test_stray_strobes();
      int resp0;
      go_idle();
      resp0 = n_resp[0];
      en[0] = 1'b1;
      cycles(2);
      fin_rx[0] = 1'b1; fin_tx[0] = 1'b1; pass_tx[0] = 1'b1;
      @(negedge clk);
      fin_rx[0] = 1'b0; fin_tx[0] = 1'b0; pass_tx[0] = 1'b0;
      cycles(12);
      checks++;
      if (crx[0] !== 1'b0 || ctx[0] !== 1'b0) begin
         failures++;
         $display("FAIL stray_check got crx=%b ctx=%b want 0/0", crx[0], ctx[0]);
      end
      checks++;
      if ((n_resp[0] - resp0) !== 0) begin
         failures++;
         $display("FAIL stray_resp got=%0d responses want=0", n_resp[0] - resp0);
      end
      checks++;
      if (err[0] !== 1'b0 || pend[0] !== 1'b0) begin
         failures++;
         $display("FAIL stray_status got err=%b end=%b want 0/0", err[0], pend[0]);
      end
   endtask

   task automatic test_abort();
      for (int v = 0; v < 2; v++) begin
         int t;
         bit seen;
         go_idle();
         en[0] = 1'b1; en[1] = 1'b1;
         t = 0;
         while (!(crx[0] && crx[1]) && t < 40) begin @(negedge clk); t++; end
         checks++;
         if ({crx[0], crx[1]} !== 2'b11) begin
            failures++;
            $display("FAIL abort_reach_check v%0d got crx=%b want 11", v, {crx[0], crx[1]});
         end
         if (v == 0) rst = 1'b1;
         else begin en[0] = 1'b0; en[1] = 1'b0; end
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if ({vld[d], code[d], err[d], ctx[d], crx[d], pend[d]} !== 9'd0) begin
               failures++;
               $display("FAIL abort_outs v%0d die%0d got=%b want=0", v, d, {vld[d], code[d], err[d], ctx[d], crx[d], pend[d]});
            end
         end
         rst = 1'b0; en[0] = 1'b1; en[1] = 1'b1;
         seen = 1'b0;
         for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (vld[0] && code[0] == 4'd1) seen = 1'b1;
         end
         checks++;
         if (seen !== 1'b1) begin
            failures++;
            $display("FAIL abort_resend v%0d got=%b want=1", v, seen);
         end
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      go_idle();
      test_reset();
      test_handshake(6);
      test_stray_strobes();
      test_abort();
      go_idle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mbinit_param_wrapper.md
Name: mbinit_param_wrapper

Overview:
- Handles the MBINIT.PARAM handshake for one die: sends a configuration request, answers the partner's request with a response, and reports completion.
- Contains two sub-FSMs sharing one sideband output: TX (own request → partner response → validation) and RX (partner request → local check → own response).
- The actual parameter comparison is done outside the block and reported back through finish/pass strobes.
- Sits under the MBINIT controller, between the sideband encoder/decoder and the parameter-check logic.

Parameters:
- SB_MSG_Width, 4, width of encoded/decoded sideband message codes.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_MBINIT_en  in  1  enables PARAM phase; low = idle/clear.
- i_decoded_sb_msg  in  SB_MSG_Width  message code received from partner.
- i_sb_valid  in  1  i_decoded_sb_msg valid.
- i_sb_busy  in  1  sideband transmitter busy (informational; not needed for FSM progress).
- i_falling_edge_busy  in  1  one-cycle strobe: current outgoing message sent.
- i_pass_tx  in  1  partner response parameters acceptable; sampled with i_finish_tx.
- i_finish_tx  in  1  one-cycle strobe: TX-side response check complete.
- i_finish_rx  in  1  one-cycle strobe: RX-side request check complete.
- o_encoded_SB_msg  out  SB_MSG_Width  outgoing message code.
- o_msg_valid  out  1  o_encoded_SB_msg valid.
- o_error_req  out  1  PARAM failure; request TRAINERROR.
- check_TX  out  1  partner response received, external validation requested.
- check_RX  out  1  partner request received, external check requested.
- o_PARAM_END  out  1  PARAM phase complete.

Behaviour:
- Encodings: REQ = 4'b0001, RESP = 4'b0010; all other codes are ignored. Codes are zero-extended if SB_MSG_Width > 4.
- Reset: i_rst high at a posedge forces both FSMs to IDLE and drives all outputs to 0 (o_encoded_SB_msg = 0). A mid-handshake reset aborts the handshake.
- i_MBINIT_en low at any posedge has the same effect as reset. When it rises again, the sequence restarts from IDLE.

TX FSM:
- IDLE → SEND_REQ one cycle after i_MBINIT_en is seen high.
- SEND_REQ: present REQ with o_msg_valid = 1, held until i_falling_edge_busy. Then go to WAIT_RESP.
- WAIT_RESP: when i_sb_valid is high and i_decoded_sb_msg = RESP, go to CHECK.
- CHECK: check_TX = 1. On i_finish_tx: if i_pass_tx = 1 go to DONE; otherwise go to ERROR.
- ERROR sets o_error_req.
- DONE and ERROR are held until disabled.

RX FSM:
- IDLE → WAIT_REQ one cycle after i_MBINIT_en is seen high.
- WAIT_REQ: when i_sb_valid is high and i_decoded_sb_msg = REQ, go to CHECK.
- CHECK: check_RX = 1 until i_finish_rx, then go to SEND_RESP.
- SEND_RESP: present RESP with o_msg_valid = 1, held until i_falling_edge_busy. Then go to DONE.

Sharing and arbitration:
- The single output slot is owned by one FSM at a time; TX wins when both need it.
- An RX response waits while TX is in SEND_REQ.
- i_falling_edge_busy completes only the message currently presented.
- Output is registered: valid/code change one cycle after the state change.
- A held-valid message from the partner is consumed once, because the receiving FSM leaves its wait state.

Strobe handling:
- finish/pass strobes arriving outside the matching CHECK state are ignored.
- A REQ/RESP arriving before its wait state is reached is not latched.

Completion and error:
- o_PARAM_END = 1 (registered) when TX = DONE and RX = DONE, held while enabled.
- o_error_req is sticky until reset or disable. While o_error_req is high, o_PARAM_END = 0.

Optional Feature:
- Macro PARAM_TIMEOUT_EN.
- Defined: a 16-bit counter (parameter TIMEOUT_CYCLES, default 8000) runs while TX is in WAIT_RESP or RX is in WAIT_REQ, and clears on leaving those states. On reaching TIMEOUT_CYCLES, o_error_req is set and both FSMs freeze.
- Undefined: no timeout; the FSMs wait indefinitely.

Test Plan:
- Two instances cross-connected (A out → B in and B out → A in), both enabled. Each drives code 0x1 with valid within 5 cycles; i_falling_edge_busy (2 cycles after busy) drops valid.
- Both check_RX = 1. A one-cycle i_finish_rx on each → each drives 0x2 with valid within 5 cycles. Then check_TX = 1 on both. i_pass_tx = 1 with i_finish_tx = 1 → o_PARAM_END = 1 on both next cycle; o_error_req = 0.
- Same flow with i_pass_tx = 0 on A at i_finish_tx → A o_error_req = 1 and o_PARAM_END = 0, sticky until i_MBINIT_en = 0.
- i_finish_rx pulsed while RX is in WAIT_REQ → ignored; check_RX stays 0 and no RESP is sent.
- i_rst (or i_MBINIT_en = 0) asserted during CHECK → next cycle all outputs 0. On re-enable, REQ 0x1 is resent.
- With PARAM_TIMEOUT_EN: REQ completes but the partner never responds → o_error_req = 1 after TIMEOUT_CYCLES cycles.
